rxdata: RTL and testbench



---
 rtl/rxdata_pkg.sv | 41 ++++
 rtl/rxdata.sv | 128 ++++++++++++
 tb/tb_rxdata.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rxdata_pkg.sv
// Shared definitions for the hex-number link: frame parser state encoding,
// ASCII framing constants and the hex digit table used in both directions.
package rxdata_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_HEX  = 2'd2
    } state_t;

    localparam logic [7:0] ASC_CR = 8'h0d;
    localparam logic [7:0] ASC_LF = 8'h0a;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_LX = 8'h78;
    localparam logic [7:0] ASC_UX = 8'h58;

    // True for '0'-'9', 'a'-'f', 'A'-'F'.
    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Nibble value of a hex digit; only meaningful when is_hex(c) holds.
    // Letters of either case have c[3:0] = 1..6, so adding 9 gives 10..15.
    function automatic logic [3:0] hex_to_nib(input logic [7:0] c);
        if (c <= 8'h39)
            return c[3:0];
        else
            return c[3:0] + 4'd9;
    endfunction

    // Reverse direction of the same table, used by the transmitter.
    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'd0, n};
        else
            return 8'h57 + {4'd0, n};
    endfunction

endpackage

// File: rtl/rxdata.sv
// ASCII hex frame parser: "0x" + 1..8 hex digits + CR/LF -> 32-bit value.
// Malformed, overlong or timed-out frames are dropped with an o_err pulse.
module rxdata
    import rxdata_pkg::*;
#(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [7:0]  i_byte,
    output logic        o_stb,
    output logic [31:0] o_data,
    output logic [3:0]  o_ndigits,
    output logic        o_err,
    output logic        o_busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_acc;
    logic [31:0] w_acc_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_tmo;
    logic        w_stb_nxt;
    logic        w_err_nxt;
    logic        w_load;
    logic        w_expire;

    // A frame in progress has gone quiet for TIMEOUT clocks; a byte arriving
    // on the same cycle takes priority because i_stb is tested first below.
    assign w_expire = (TIMEOUT != 32'd0) && (r_state != S_IDLE) && (r_tmo == TIMEOUT);

    assign o_busy = (r_state != S_IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state, accumulator update and output pulse decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_stb_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        if (i_stb) begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_byte == ASC_0)
                        w_state_nxt = S_ZERO;
                end
                S_ZERO: begin
                    if ((i_byte == ASC_LX) || (i_byte == ASC_UX)) begin
                        w_state_nxt = S_HEX;
                        w_acc_nxt   = 32'd0;
                        w_cnt_nxt   = 4'd0;
                    end else if (i_byte != ASC_0) begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
                S_HEX: begin
                    if (is_hex(i_byte)) begin
                        if (r_cnt < 4'd8) begin
                            w_acc_nxt = {r_acc[27:0], hex_to_nib(i_byte)};
                            w_cnt_nxt = r_cnt + 4'd1;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_err_nxt   = 1'b1;
                        end
                    end else if ((i_byte == ASC_CR) || (i_byte == ASC_LF)) begin
                        w_state_nxt = S_IDLE;
                        if (r_cnt != 4'd0) begin
                            w_stb_nxt = 1'b1;
                            w_load    = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_expire) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
        end
    end

    // Accumulator, digit count and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc     <= 32'd0;
            r_cnt     <= 4'd0;
            o_stb     <= 1'b0;
            o_err     <= 1'b0;
            o_data    <= 32'd0;
            o_ndigits <= 4'd0;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            o_stb <= w_stb_nxt;
            o_err <= w_err_nxt;
            if (w_load) begin
                o_data    <= r_acc;
                o_ndigits <= r_cnt;
            end
        end
    end

    // Inter-byte timer: cleared by every byte and while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_stb || (r_state == S_IDLE))
            r_tmo <= 32'd0;
        else
            r_tmo <= r_tmo + 32'd1;
    end

endmodule

// File: tb/tb_rxdata.sv
// Scoreboard bench for rxdata: stimulus pushes expected o_stb/o_err events
// (kind, value, digit count, cycle); a negedge monitor pops and compares.
module tb_rxdata;

    localparam logic [31:0] T = 32'd16;

    localparam int K_STB = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [3:0]  nd;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [7:0]  bt  = 8'h00;
    logic        o_stb;
    logic [31:0] o_data;
    logic [3:0]  o_ndigits;
    logic        o_err;
    logic        o_busy;

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_fail = 0;

    rxdata #(.TIMEOUT(T)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_stb     (stb),
        .i_byte    (bt),
        .o_stb     (o_stb),
        .o_data    (o_data),
        .o_ndigits (o_ndigits),
        .o_err     (o_err),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (o_stb || o_err) begin
            n_vec++;
            if (o_stb && o_err) begin
                n_fail++;
                $display("FAIL both_pulses cyc=%0d: o_stb and o_err high together", cyc);
            end else if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d: got stb=%0b err=%0b data=%h, required none",
                         cyc, o_stb, o_err, o_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ((o_stb ? K_STB : K_ERR) != e.kind || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL event_kind_time: got %s at cyc %0d, required %s at cyc %0d",
                             o_stb ? "stb" : "err", cyc, (e.kind == K_STB) ? "stb" : "err", e.cyc);
                end else if (o_stb && (o_data != e.data || o_ndigits != e.nd)) begin
                    n_fail++;
                    $display("FAIL frame_value: got data=%h nd=%0d, required data=%h nd=%0d",
                             o_data, o_ndigits, e.data, e.nd);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] d, input logic [3:0] n, input int c);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.nd   = n;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Drive one byte for one clock, starting at a negedge; optionally
    // expect an output event one cycle after it is sampled.
    task automatic send(input logic [7:0] b, input int kind = 0,
                        input logic [31:0] d = 32'd0, input logic [3:0] n = 4'd0);
        if (kind != 0)
            push(kind, d, n, cyc + 1);
        stb = 1'b1;
        bt  = b;
        @(negedge clk);
        stb = 1'b0;
        bt  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int last;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_stb",  {31'd0, o_stb},      32'd0);
        chk("rst_err",  {31'd0, o_err},      32'd0);
        chk("rst_data", o_data,              32'd0);
        chk("rst_nd",   {28'd0, o_ndigits},  32'd0);
        chk("rst_busy", {31'd0, o_busy},     32'd0);

        // Full 8-digit frame.
        send_str("0x12345678");
        chk("busy_in_frame", {31'd0, o_busy}, 32'd1);
        send(8'h0d, K_STB, 32'h12345678, 4'd8);

        // Mixed case, CR LF terminator, then a stray LF.
        send_str("0xABcd");
        send(8'h0d, K_STB, 32'h0000abcd, 4'd4);
        send(8'h0a);
        send(8'h0a);
        idle(2);
        chk("busy_after_crlf", {31'd0, o_busy}, 32'd0);

        // Nine digits overflow; trailing CR ignored; outputs hold.
        send_str("0x12345678");
        send("9", K_ERR);
        send(8'h0d);
        idle(2);
        chk("hold_data", o_data, 32'h0000abcd);
        chk("hold_nd",   {28'd0, o_ndigits}, 32'd4);

        // Leading junk and repeated zeros.
        send_str("zq00x7");
        send(8'h0d, K_STB, 32'h00000007, 4'd1);

        // No digits before terminator.
        send_str("0x");
        send(8'h0d, K_ERR);

        // Bad byte after the leading zero, and bad byte among digits.
        send("0");
        send("g", K_ERR);
        send_str("0x1");
        send("z", K_ERR);
        idle(2);

        // Timeout mid-frame.
        send_str("0x12");
        last = cyc;
        push(K_ERR, 32'd0, 4'd0, last + int'(T) + 1);
        idle(5);
        chk("busy_waiting", {31'd0, o_busy}, 32'd1);
        idle(int'(T) + 2);
        chk("busy_after_timeout", {31'd0, o_busy}, 32'd0);
        send_str("0x5");
        send(8'h0d, K_STB, 32'h00000005, 4'd1);

        // Byte arriving exactly on the expiry cycle is accepted.
        send_str("0x3");
        idle(int'(T));
        send("4");
        send(8'h0d, K_STB, 32'h00000034, 4'd2);

        // Reset mid-frame: no error, frame discarded.
        send_str("0x9a");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("busy_after_reset", {31'd0, o_busy}, 32'd0);
        send_str("0xff");
        send(8'h0d, K_STB, 32'h000000ff, 4'd2);

        idle(5);
        chk("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
